azadi_wb_responder: RTL and testbench

AZADI_WB_RESPONDER -- requirements
Module: azadi_wb_responder

---
 rtl/azadi_wb_pkg.sv | 24 ++
 rtl/azadi_wb_mbox_fifo.sv | 65 ++++++
 rtl/azadi_wb_responder.sv | 158 +++++++++++++++
 tb/tb_azadi_wb_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/azadi_wb_pkg.sv
// Shared definitions for the Azadi Wishbone responder: FSM states,
// register offsets inside the 256-byte window and register bit positions.
package azadi_wb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } wb_state_e;

  localparam logic [7:0] OFF_CTRL      = 8'h00;
  localparam logic [7:0] OFF_CPB       = 8'h04;
  localparam logic [7:0] OFF_STATUS    = 8'h08;
  localparam logic [7:0] OFF_MBOX_DATA = 8'h0C;
  localparam logic [7:0] OFF_MBOX_STAT = 8'h10;

  localparam int CTRL_PROG_BIT    = 0;
  localparam int CTRL_SOC_RST_BIT = 1;

  localparam int MBOX_CNT_W     = 5;
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 10;

endpackage

// File: rtl/azadi_wb_mbox_fifo.sv
// Mailbox FIFO: power-of-two depth, head word presented combinationally.
// A push while full is accepted only if a pop frees a slot in the same cycle;
// a pop while empty is ignored.
module azadi_wb_mbox_fifo
  import azadi_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DW-1:0]         wdata_i,
  output logic [DW-1:0]         rdata_o,
  output logic [MBOX_CNT_W-1:0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]         mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MBOX_CNT_W-1:0] cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full_o  = (cnt_q == MBOX_CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + MBOX_CNT_W'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - MBOX_CNT_W'(1);
  end

  // pointer and count registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage array, no reset needed since reads are gated by the count
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/azadi_wb_responder.sv
// Wishbone register responder: CTRL / CPB / STATUS registers in a 256-byte
// window, plus an optional mailbox FIFO enabled by defining AZADI_WB_MBOX_EN.
// Every hit is acked exactly one cycle later; writes commit on the hit edge.
module azadi_wb_responder
  import azadi_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter logic [15:0] CLKS_PER_BIT_RST = 16'd868,
  parameter int          MBOX_DEPTH       = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] clks_per_bit_o,
  output logic        prog_o,
  output logic        soc_rst_req_o,
  input  logic [31:0] soc_status_i,
  output logic [31:0] mbox_rdata_o,
  output logic        mbox_valid_o,
  input  logic        mbox_ready_i
);

  wb_state_e   state_q, state_d;
  logic        prog_q, prog_d, soc_rst_q, soc_rst_d;
  logic [15:0] cpb_q, cpb_d;
  logic [31:0] rdata_q, rdata_d, rd_mux, mbox_stat;
  logic        hit, wr_en;
  logic [7:0]  off;
  logic        unused_dat;

  assign off        = wbs_adr_i[7:0];
  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr_en      = (state_q == ST_IDLE) & hit & wbs_we_i;
  assign unused_dat = ^wbs_dat_i[31:16];

`ifdef AZADI_WB_MBOX_EN
  logic                  push_req, fifo_full, fifo_empty, pop_eff;
  logic [MBOX_CNT_W-1:0] fifo_cnt;
  logic                  ovf_q, ovf_d;

  assign push_req = wr_en & (off == OFF_MBOX_DATA) & (wbs_sel_i == 4'hF);
  assign pop_eff  = mbox_ready_i & ~fifo_empty;

  azadi_wb_mbox_fifo #(.DEPTH(MBOX_DEPTH), .DW(32)) u_mbox (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push_req),
    .pop_i   (mbox_ready_i),
    .wdata_i (wbs_dat_i),
    .rdata_o (mbox_rdata_o),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // overflow is sticky on a dropped push, cleared by writing 1 to its bit
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && off == OFF_MBOX_STAT && wbs_sel_i[1] && wbs_dat_i[STAT_OVF_BIT]) ovf_d = 1'b0;
    if (push_req && fifo_full && !pop_eff) ovf_d = 1'b1;
  end

  // overflow flag register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign mbox_stat    = {21'h0, ovf_q, fifo_full, fifo_empty, 3'b000, fifo_cnt};
  assign mbox_valid_o = ~fifo_empty;
`else
  logic unused_mbox_ready;
  assign unused_mbox_ready = mbox_ready_i;
  assign mbox_stat    = 32'h0;
  assign mbox_valid_o = 1'b0;
  assign mbox_rdata_o = 32'h0;
`endif

  // read-data selection for the addressed register
  always_comb begin
    rd_mux = 32'h0;
    case (off)
      OFF_CTRL: begin
        rd_mux[CTRL_PROG_BIT]    = prog_q;
        rd_mux[CTRL_SOC_RST_BIT] = soc_rst_q;
      end
      OFF_CPB:       rd_mux = {16'h0, cpb_q};
      OFF_STATUS:    rd_mux = soc_status_i;
      OFF_MBOX_STAT: rd_mux = mbox_stat;
      default:       rd_mux = 32'h0;
    endcase
  end

  // FSM next state, register writes and read-data capture at the hit
  always_comb begin
    state_d   = state_q;
    prog_d    = prog_q;
    soc_rst_d = soc_rst_q;
    cpb_d     = cpb_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_ACK;
          rdata_d = wbs_we_i ? 32'h0 : rd_mux;
          if (wbs_we_i) begin
            case (off)
              OFF_CTRL: begin
                if (wbs_sel_i[0]) begin
                  prog_d    = wbs_dat_i[CTRL_PROG_BIT];
                  soc_rst_d = wbs_dat_i[CTRL_SOC_RST_BIT];
                end
              end
              OFF_CPB: begin
                if (wbs_sel_i[0]) cpb_d[7:0]  = wbs_dat_i[7:0];
                if (wbs_sel_i[1]) cpb_d[15:8] = wbs_dat_i[15:8];
              end
              default: ;
            endcase
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state and register file
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      prog_q    <= 1'b0;
      soc_rst_q <= 1'b1;
      cpb_q     <= CLKS_PER_BIT_RST;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      prog_q    <= prog_d;
      soc_rst_q <= soc_rst_d;
      cpb_q     <= cpb_d;
      rdata_q   <= rdata_d;
    end
  end

  assign wbs_ack_o      = (state_q == ST_ACK);
  assign wbs_dat_o      = wbs_ack_o ? rdata_q : 32'h0;
  assign prog_o         = prog_q;
  assign soc_rst_req_o  = soc_rst_q;
  assign clks_per_bit_o = cpb_q;

endmodule

// File: tb/tb_azadi_wb_responder.sv
module tb_azadi_wb_responder;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [15:0] clks_per_bit_o;
  logic        prog_o, soc_rst_req_o;
  logic [31:0] soc_status_i;
  logic [31:0] mbox_rdata_o;
  logic        mbox_valid_o, mbox_ready_i;

  localparam logic [31:0] BASE = 32'h3000_0000;

  typedef struct {
    logic        chk;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  azadi_wb_responder dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .wbs_stb_i      (wbs_stb_i),
    .wbs_cyc_i      (wbs_cyc_i),
    .wbs_we_i       (wbs_we_i),
    .wbs_sel_i      (wbs_sel_i),
    .wbs_dat_i      (wbs_dat_i),
    .wbs_adr_i      (wbs_adr_i),
    .wbs_ack_o      (wbs_ack_o),
    .wbs_dat_o      (wbs_dat_o),
    .clks_per_bit_o (clks_per_bit_o),
    .prog_o         (prog_o),
    .soc_rst_req_o  (soc_rst_req_o),
    .soc_status_i   (soc_status_i),
    .mbox_rdata_o   (mbox_rdata_o),
    .mbox_valid_o   (mbox_valid_o),
    .mbox_ready_i   (mbox_ready_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every ack consumes one expected entry
  always @(negedge wb_clk_i) begin
    if (wbs_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) chk("rd_data", wbs_dat_o, e.d);
      end
    end
  end

  // one Wishbone access; call and return at posedge+1
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                     input logic [3:0] sel, input logic [31:0] exp, input logic do_pop);
    exp_t e;
    int   lat;
    e.chk = !we;
    e.d   = exp;
    exp_q.push_back(e);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
    mbox_ready_i = do_pop;
    lat = 0;
    do begin
      @(posedge wb_clk_i); #1;
      lat++;
      mbox_ready_i = 1'b0;
    end while (wbs_ack_o !== 1'b1 && lat < 5);
    chk("ack_latency", lat, 1);
    if (wbs_ack_o === 1'b1) begin
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      chk("ack_pulse", {31'h0, wbs_ack_o}, 32'h0);
    end else begin
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end
  endtask

  task automatic idle_no_ack(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o === 1'b1) seen = 1'b1;
    end
    chk(name, {31'h0, seen}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_dat_i = 0; wbs_adr_i = 0;
    soc_status_i = 32'h0; mbox_ready_i = 0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_ack",     {31'h0, wbs_ack_o},     32'h0);
    chk("rst_dat",     wbs_dat_o,              32'h0);
    chk("rst_prog",    {31'h0, prog_o},        32'h0);
    chk("rst_socrst",  {31'h0, soc_rst_req_o}, 32'h1);
    chk("rst_cpb",     {16'h0, clks_per_bit_o}, 32'd868);
    chk("rst_mvalid",  {31'h0, mbox_valid_o},  32'h0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;

    // reset values through the bus
    bus(0, BASE + 32'h04, 0, 4'hF, 32'h0000_0364, 0);
    bus(0, BASE + 32'h00, 0, 4'hF, 32'h0000_0002, 0);

    // byte-selected CPB writes
    bus(1, BASE + 32'h04, 32'h0000_00D9, 4'h1, 0, 0);
    chk("cpb_lo", {16'h0, clks_per_bit_o}, 32'h0000_03D9);
    bus(1, BASE + 32'h04, 32'hABCD_1234, 4'h2, 0, 0);
    chk("cpb_hi", {16'h0, clks_per_bit_o}, 32'h0000_12D9);
    bus(1, BASE + 32'h04, 32'h0000_FFFF, 4'h0, 0, 0);
    bus(0, BASE + 32'h04, 0, 4'hF, 32'h0000_12D9, 0);

    // CTRL
    bus(1, BASE + 32'h00, 32'h0000_0001, 4'h1, 0, 0);
    chk("ctrl_prog",   {31'h0, prog_o},        32'h1);
    chk("ctrl_socrst", {31'h0, soc_rst_req_o}, 32'h0);
    bus(1, BASE + 32'h00, 32'h0000_0302, 4'h2, 0, 0);
    bus(0, BASE + 32'h00, 0, 4'hF, 32'h0000_0001, 0);

    // STATUS sampled at the hit, RO
    soc_status_i = 32'hDEAD_BEEF;
    bus(1, BASE + 32'h08, 32'h1234_5678, 4'hF, 0, 0);
    bus(0, BASE + 32'h08, 0, 4'hF, 32'hDEAD_BEEF, 0);

    // decode misses
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = 32'h3000_1000;
    idle_no_ack("miss_window", 10);
    wbs_cyc_i = 0; wbs_adr_i = BASE;
    idle_no_ack("miss_nocyc", 3);
    wbs_stb_i = 0;

    // unmapped offset in the window
    bus(0, BASE + 32'h40, 0, 4'hF, 32'h0, 0);
    bus(1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0);

`ifdef AZADI_WB_MBOX_EN
    for (int i = 0; i < 5; i++) bus(1, BASE + 32'h0C, 32'hA000_0000 + i, 4'hF, 0, 0);
    bus(0, BASE + 32'h10, 0, 4'hF, 32'h0000_0604, 0);
    chk("mbox_head0",  mbox_rdata_o, 32'hA000_0000);
    chk("mbox_valid",  {31'h0, mbox_valid_o}, 32'h1);
    bus(1, BASE + 32'h10, 32'h0000_0400, 4'hF, 0, 0);
    bus(0, BASE + 32'h10, 0, 4'hF, 32'h0000_0204, 0);
    mbox_ready_i = 1;
    repeat (2) @(posedge wb_clk_i);
    #1 mbox_ready_i = 0;
    chk("mbox_head2", mbox_rdata_o, 32'hA000_0002);
    bus(1, BASE + 32'h0C, 32'hB000_0000, 4'hF, 0, 1);
    bus(0, BASE + 32'h10, 0, 4'hF, 32'h0000_0002, 0);
    chk("mbox_head3", mbox_rdata_o, 32'hA000_0003);
    bus(1, BASE + 32'h0C, 32'hC000_0000, 4'h7, 0, 0);
    bus(0, BASE + 32'h10, 0, 4'hF, 32'h0000_0002, 0);
    bus(1, BASE + 32'h0C, 32'hB000_0001, 4'hF, 0, 0);
    bus(1, BASE + 32'h0C, 32'hB000_0002, 4'hF, 0, 0);
    bus(1, BASE + 32'h0C, 32'hB000_0003, 4'hF, 0, 1);
    bus(0, BASE + 32'h10, 0, 4'hF, 32'h0000_0204, 0);
    chk("mbox_full_pp", mbox_rdata_o, 32'hB000_0000);
    mbox_ready_i = 1;
    repeat (6) @(posedge wb_clk_i);
    #1 mbox_ready_i = 0;
    bus(0, BASE + 32'h10, 0, 4'hF, 32'h0000_0100, 0);
    chk("mbox_empty", {31'h0, mbox_valid_o}, 32'h0);
`else
    bus(1, BASE + 32'h0C, 32'h1111_2222, 4'hF, 0, 0);
    bus(0, BASE + 32'h0C, 0, 4'hF, 32'h0, 0);
    bus(0, BASE + 32'h10, 0, 4'hF, 32'h0, 0);
    chk("nombox_valid", {31'h0, mbox_valid_o}, 32'h0);
    chk("nombox_rdata", mbox_rdata_o, 32'h0);
`endif

    // reset in the middle of an ACK
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE; wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    chk("pre_rst_ack", {31'h0, wbs_ack_o}, 32'h1);
    wb_rst_i = 1'b1;
    #1;
    chk("midack_ack",    {31'h0, wbs_ack_o},     32'h0);
    chk("midack_socrst", {31'h0, soc_rst_req_o}, 32'h1);
    chk("midack_prog",   {31'h0, prog_o},        32'h0);
    chk("midack_cpb",    {16'h0, clks_per_bit_o}, 32'd868);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    idle_no_ack("post_rst_noack", 4);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
